div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative 64-bit integer divider in the execute stage, directly downstream of decode operand selection.
- Consumes the two prepared operands (rd1 = dividend, rd2 = divisor) for DIV/DIVU/REM/REMU and their W forms. W forms arrive already sign- or zero-extended to 64 bits.
- Radix-2 restoring division, one quotient bit per cycle.
- Holds the execute stage via a valid/ready handshake until the result is accepted.

Parameters:
- WIDTH, 64, operand and result width in bits. Iteration counter width is $clog2(WIDTH)+1.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request from execute
- in_ready  output  1  divider can accept a request this cycle
- a  input  WIDTH  dividend (rd1)
- b  input  WIDTH  divisor (rd2)
- op  input  2  div_op_t: DIV_S=0, DIVU_S=1, REM_S=2, REMU_S=3
- is_word  input  1  W variant: result is sign-extended from bit 31
- flush  input  1  kill the in-flight operation
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  quotient or remainder

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, counter=0, all datapath registers 0.
  - in_ready=1, out_valid=0, result=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch op and is_word.
  - Signed ops: take |a| and |b|; record neg_q = a[63]^b[63] (only if b!=0) and neg_r = a[63].
  - Load the remainder register with 0 and the quotient register with |a|; counter=WIDTH; go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle: shift {rem,quo} left 1. If shifted rem >= |b|, subtract |b| and set quo[0]=1. Decrement counter.
  - When counter reaches 1 this cycle, go to DONE next cycle.
  - Issue-to-out_valid latency is exactly WIDTH+1 cycles (65).
- DONE:
  - out_valid=1. result is combinational from the final registers and stable while out_valid=1.
  - On out_ready, go to IDLE the next cycle. A new request is not accepted in the same cycle as out_ready.
- Result selection:
  - DIV_S: neg_q ? -quo : quo.
  - DIVU_S: quo.
  - REM_S: neg_r ? -rem : rem.
  - REMU_S: rem.
  - is_word=1: result = {{32{r[31]}}, r[31:0]}.
- Division by zero (b==0): quotient=all ones, remainder=a, with no sign fix on the quotient. W forms therefore give 0xFFFFFFFFFFFFFFFF, and remainder = sign-extended a[31:0].
- Signed overflow: a=0x8000000000000000 with b=-1 gives quotient=a and remainder=0. This falls out of the magnitude datapath; it must be checked, not special-cased.
- DIVW overflow: a=0xFFFFFFFF80000000 with b=-1 gives 0xFFFFFFFF80000000.
- Flush:
  - In any state, flush=1 forces state=IDLE and out_valid=0 at the next edge.
  - Flush has priority over in_valid in the same cycle; no request is latched.
- Reset mid-operation aborts immediately with no output.
- in_valid while BUSY/DONE is ignored. The upstream stage holds its request until in_ready and out_valid are both seen, per the execute stall logic.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if b==0, or a signed op with a=most-negative and b=-1, load the final quotient/remainder directly and go to DONE. Latency is 1 cycle to out_valid instead of 65. Results are bit-identical to the iterative path.
- Undefined: every operation takes the full WIDTH+1 cycles.

Decomposition:
- Package pipes: div_op_t enum, div_state_t enum {IDLE, BUSY, DONE}, localparam DIV_CNT_W.
- word_t and u1 come from common.
- One sub-module, div_step: purely combinational single restoring step. Inputs rem, quo, divisor; outputs next rem and quo. Instantiated once in div_unit.

Test Plan:
- DIV_S a=-7 (0xFF..F9), b=2 -> out_valid exactly 65 cycles after issue; result=0xFFFFFFFFFFFFFFFD (-3). Repeat as REM_S -> 0xFFFFFFFFFFFFFFFF (-1).
- DIVU_S a=0xFFFFFFFFFFFFFFFF, b=0 -> result all ones. REMU_S, same operands -> result=a. With DIV_EARLY_OUT_EN, out_valid 1 cycle after issue.
- DIV_S a=0x8000000000000000, b=0xFFFFFFFFFFFFFFFF -> 0x8000000000000000. REM_S -> 0.
- is_word DIVW a=0xFFFFFFFF80000000, b=-1 -> 0xFFFFFFFF80000000. REMUW a=0x00000000FFFFFFFF, b=0x10 -> 0x000000000000000F.
- Issue DIVU 100/7, assert flush at cycle 30 -> out_valid never rises, in_ready=1 next cycle. Immediately issue DIVU 100/7 -> 14 after 65 cycles.
- Hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable. Drop reset mid-BUSY -> out_valid=0, in_ready=1 asynchronously.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative integer divider.
package div_unit_pkg;

  localparam int DIV_WIDTH = 64;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef logic [DIV_WIDTH-1:0] word_t;
  typedef logic                 u1;

  typedef enum logic [1:0] {
    DIV_S  = 2'd0,
    DIVU_S = 2'd1,
    REM_S  = 2'd2,
    REMU_S = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // DIV and REM work on magnitudes and fix the sign afterwards.
  function automatic u1 op_is_signed(input div_op_t op);
    return (op == DIV_S) || (op == REM_S);
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division step, purely combinational.
// The remainder is widened by one bit so the shifted value can never overflow
// before it is compared with the divisor.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Shift {rem,quo} left by one and subtract the divisor when it fits.
  always_comb begin
    w_shift = {i_rem, i_quo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, i_div});
    // When w_ge holds the difference is below 2^WIDTH, so the low bits suffice.
    w_diff  = w_shift[WIDTH-1:0] - i_div;
    o_rem   = w_ge ? w_diff : w_shift[WIDTH-1:0];
    o_quo   = {i_quo[WIDTH-2:0], w_ge};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 64-bit integer divider (DIV/DIVU/REM/REMU and W forms).
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the
// iteration and complete one cycle after issue with identical results.
//
// Handshake: a request is taken when in_valid is high and in_ready is high
// (state IDLE) and flush is low; the result is held with out_valid high until
// a cycle with out_ready high, after which the unit returns to IDLE. flush
// returns to IDLE from any state and wins over a same-cycle request.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  div_op_t          op,
  input  logic             is_word,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output div_state_t       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  div_op_t          r_op;
  logic             r_word;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_signed;
  logic             w_b_zero;
  logic             w_early;
  logic             w_take;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_sel;

  // Operand preparation: magnitudes and sign flags for the signed ops.
  always_comb begin
    w_signed = op_is_signed(op);
    w_b_zero = (b == '0);
    w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
    w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
    w_early  = w_b_zero ||
               (w_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1));
`else
    w_early  = 1'b0;
`endif
    w_take   = (r_state == IDLE) && in_valid && !flush;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_early ? DONE : BUSY;
      BUSY:    if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  // Datapath: load magnitudes on issue, one restoring step per BUSY cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_op    <= DIV_S;
      r_word  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_take) begin
      r_op    <= op;
      r_word  <= is_word;
      r_div   <= w_abs_b;
      r_neg_q <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && !w_b_zero;
      r_neg_r <= w_signed && a[WIDTH-1];
      // Early-out loads the values the iteration would have produced:
      // b==0 gives quo=all ones, rem=|a|; overflow gives quo=|a|, rem=0.
      r_rem   <= (w_early && w_b_zero) ? w_abs_a : '0;
      r_quo   <= (w_early && w_b_zero) ? '1 : w_abs_a;
      r_cnt   <= w_early ? '0 : CNT_W'(WIDTH);
    end else if (r_state == BUSY) begin
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  // Result selection and W-form sign extension, straight from the registers.
  always_comb begin
    case (r_op)
      DIV_S:   w_sel = r_neg_q ? -r_quo : r_quo;
      DIVU_S:  w_sel = r_quo;
      REM_S:   w_sel = r_neg_r ? -r_rem : r_rem;
      default: w_sel = r_rem;
    endcase
    result    = r_word ? {{(WIDTH-32){w_sel[31]}}, w_sel[31:0]} : w_sel;
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  div_op_t     op;
  logic        is_word;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  div_state_t  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = 65;
`endif
  localparam int LAT_FULL = 65;

  div_unit #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .is_word   (is_word),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = DIV_S;
    is_word = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Driver: issue one request (DUT must be IDLE); lat = cycles from issue to
  // out_valid, or -1 on timeout. Accepts the result when accept is set.
  task automatic do_op(input div_op_t o, input logic [63:0] va, input logic [63:0] vb,
                       input logic w, input logic accept,
                       output logic [63:0] res, output int lat);
    @(negedge clk);
    op = o; a = va; b = vb; is_word = w; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    res = '0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    res = result;
    if (accept && lat > 0) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (result !== 64'h0) $display("FAIL reset_result got %h want 0", result); else n_pass++;
    n_checks++; if (dbg_state !== IDLE) $display("FAIL reset_state got %0d want IDLE", dbg_state); else n_pass++;
  endtask

  task automatic test_signed();
    logic [63:0] r; int l;
    do_op(DIV_S, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, r, l);
    n_checks++; if (l !== LAT_FULL) $display("FAIL div_neg_latency got %0d want %0d", l, LAT_FULL); else n_pass++;
    n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_neg got %h want fffffffffffffffd", r); else n_pass++;
    do_op(REM_S, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, r, l);
    n_checks++; if (l !== LAT_FULL) $display("FAIL rem_neg_latency got %0d want %0d", l, LAT_FULL); else n_pass++;
    n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL rem_neg got %h want ffffffffffffffff", r); else n_pass++;
  endtask

  task automatic test_div_zero();
    logic [63:0] r; int l;
    do_op(DIVU_S, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, r, l);
    n_checks++; if (l !== LAT_SPECIAL) $display("FAIL divu_zero_latency got %0d want %0d", l, LAT_SPECIAL); else n_pass++;
    n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL divu_zero got %h want all ones", r); else n_pass++;
    do_op(REMU_S, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, r, l);
    n_checks++; if (l !== LAT_SPECIAL) $display("FAIL remu_zero_latency got %0d want %0d", l, LAT_SPECIAL); else n_pass++;
    n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL remu_zero got %h want ffffffffffffffff", r); else n_pass++;
    // Signed divide by zero: no sign fix on quotient, remainder equals a.
    do_op(DIV_S, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b0, 1'b1, r, l);
    n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL div_zero_signed got %h want all ones", r); else n_pass++;
    do_op(REM_S, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b0, 1'b1, r, l);
    n_checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFF9) $display("FAIL rem_zero_signed got %h want fffffffffffffff9", r); else n_pass++;
    // W form remainder by zero: sign-extended a[31:0].
    do_op(REMU_S, 64'h0000_0000_8000_0005, 64'd0, 1'b1, 1'b1, r, l);
    n_checks++; if (r !== 64'hFFFF_FFFF_8000_0005) $display("FAIL remuw_zero got %h want ffffffff80000005", r); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [63:0] r; int l;
    do_op(DIV_S, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, r, l);
    n_checks++; if (l !== LAT_SPECIAL) $display("FAIL div_ovf_latency got %0d want %0d", l, LAT_SPECIAL); else n_pass++;
    n_checks++; if (r !== 64'h8000_0000_0000_0000) $display("FAIL div_ovf got %h want 8000000000000000", r); else n_pass++;
    do_op(REM_S, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, r, l);
    n_checks++; if (r !== 64'h0) $display("FAIL rem_ovf got %h want 0", r); else n_pass++;
  endtask

  task automatic test_word();
    logic [63:0] r; int l;
    do_op(DIV_S, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, r, l);
    n_checks++; if (l !== LAT_FULL) $display("FAIL divw_ovf_latency got %0d want %0d", l, LAT_FULL); else n_pass++;
    n_checks++; if (r !== 64'hFFFF_FFFF_8000_0000) $display("FAIL divw_ovf got %h want ffffffff80000000", r); else n_pass++;
    do_op(REMU_S, 64'h0000_0000_FFFF_FFFF, 64'h10, 1'b1, 1'b1, r, l);
    n_checks++; if (r !== 64'h0000_0000_0000_000F) $display("FAIL remuw got %h want f", r); else n_pass++;
  endtask

  task automatic test_flush();
    logic [63:0] r; int l; int seen;
    @(negedge clk);
    op = DIVU_S; a = 64'd100; b = 64'd7; is_word = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (30) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", out_valid); else n_pass++;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL flush_no_result got %0d valid cycles want 0", seen); else n_pass++;
    // Flush and request in the same IDLE cycle: the request is dropped.
    op = DIVU_S; a = 64'd9; b = 64'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_checks++; if (dbg_state !== IDLE) $display("FAIL flush_priority got state %0d want IDLE", dbg_state); else n_pass++;
    do_op(DIVU_S, 64'd100, 64'd7, 1'b0, 1'b1, r, l);
    n_checks++; if (l !== LAT_FULL) $display("FAIL after_flush_latency got %0d want %0d", l, LAT_FULL); else n_pass++;
    n_checks++; if (r !== 64'd14) $display("FAIL after_flush got %0d want 14", r); else n_pass++;
  endtask

  task automatic test_hold();
    logic [63:0] r; int l; int bad;
    do_op(DIVU_S, 64'd1000, 64'd3, 1'b0, 1'b0, r, l);
    n_checks++; if (r !== 64'd333) $display("FAIL hold_first got %0d want 333", r); else n_pass++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 64'd333 || in_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL hold_stable got %0d unstable cycles want 0", bad); else n_pass++;
    // out_ready with a concurrent request: the request is not taken this cycle.
    op = DIVU_S; a = 64'd50; b = 64'd5; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (dbg_state !== IDLE) $display("FAIL accept_no_issue got state %0d want IDLE", dbg_state); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL accept_out_valid got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op = DIVU_S; a = 64'd100; b = 64'd7; is_word = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (dbg_state !== BUSY) $display("FAIL mid_busy got state %0d want BUSY", dbg_state); else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL async_reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL async_reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (result !== 64'h0) $display("FAIL async_reset_result got %h want 0", result); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_signed();
    test_div_zero();
    test_overflow();
    test_word();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
